// File: rtl/mdio_pkg.sv
// Shared constants, frame layout and FSM state type for the Clause-22 MDIO master.
// Macro MDIO_PREAMBLE_EN adds the PREAMBLE state to the state type.
package mdio_pkg;
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int FRAME_LEN    = 32;
  localparam int READ_OE_CUT  = 14;
  localparam int READ_DATA_LO = 16;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] wdata;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE,
`ifdef MDIO_PREAMBLE_EN
    PREAMBLE,
`endif
    FRAME,
    DONE
  } state_t;

  function automatic logic cmd_valid(input frame_t cmd);
    return (cmd.st == ST_CODE) && ((cmd.op == OP_WRITE) || (cmd.op == OP_READ));
  endfunction
endpackage

// File: rtl/mdio_controller_clkgen.sv
// MDC divider: toggles MDC every DIV_HALF clocks and flags the clock edge on which MDC rises or falls.
module mdc_clkgen #(
  parameter int DIV_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);
  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = (cnt == CW'(DIV_HALF - 1));
  // Enables are high in the cycle before the edge, so the FSM acts on the same edge MDC toggles.
  assign mdc_rise = wrap & ~mdc;
  assign mdc_fall = wrap & mdc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mdio_controller.sv
// Clause-22 MDIO master: serialises one 32-bit management frame per command and captures read data.
// Macro MDIO_PREAMBLE_EN prepends PREAMBLE_LEN driven ones to every frame.
module mdio_controller
  import mdio_pkg::*;
#(
`ifdef MDIO_PREAMBLE_EN
  parameter int PREAMBLE_LEN = 32,
`endif
  parameter int DIV_HALF = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);
  localparam logic [4:0] OE_CUT   = 5'(READ_OE_CUT);
  localparam logic [4:0] RD_LO    = 5'(READ_DATA_LO);

  logic        mdc_rise, mdc_fall;
  state_t      state, state_d;
  frame_t      cmd, cmd_d;
  logic [31:0] cmd_bits;
  logic [4:0]  n, n_d, n_nxt;
  logic        active, active_d;
  logic        out_q, out_d, oe_q, oe_d, busy_q, busy_d, rdy_q, rdy_d;
  logic [14:0] shreg, shreg_d;
  logic [15:0] rd_q, rd_d;
  logic        is_read;
`ifdef MDIO_PREAMBLE_EN
  localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  logic [PW-1:0] pre_cnt, pre_d;
`endif

  mdc_clkgen #(.DIV_HALF(DIV_HALF)) u_clkgen (
    .clk     (CLK),
    .rst     (RESET),
    .mdc     (MDC),
    .mdc_rise(mdc_rise),
    .mdc_fall(mdc_fall)
  );

  assign cmd_bits = cmd;
  assign is_read  = (cmd.op == OP_READ);
  // active marks that bit n is already on the bus; the first falling edge drives bit 0.
  assign n_nxt    = active ? n + 5'd1 : 5'd0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cmd    <= '0;
      n      <= '0;
      active <= 1'b0;
      out_q  <= 1'b0;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
      shreg  <= '0;
      rd_q   <= '0;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt <= '0;
`endif
    end else begin
      state  <= state_d;
      cmd    <= cmd_d;
      n      <= n_d;
      active <= active_d;
      out_q  <= out_d;
      oe_q   <= oe_d;
      busy_q <= busy_d;
      rdy_q  <= rdy_d;
      shreg  <= shreg_d;
      rd_q   <= rd_d;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt <= pre_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    cmd_d    = cmd;
    n_d      = n;
    active_d = active;
    out_d    = out_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    rdy_d    = 1'b0;
    shreg_d  = shreg;
    rd_d     = rd_q;
`ifdef MDIO_PREAMBLE_EN
    pre_d    = pre_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (MDIO_START && cmd_valid(frame_t'(T_DATA))) begin
          cmd_d    = frame_t'(T_DATA);
          busy_d   = 1'b1;
          active_d = 1'b0;
          n_d      = '0;
`ifdef MDIO_PREAMBLE_EN
          state_d  = PREAMBLE;
`else
          state_d  = FRAME;
`endif
        end
      end
`ifdef MDIO_PREAMBLE_EN
      PREAMBLE: begin
        if (mdc_fall) begin
          oe_d = 1'b1;
          if (!active) begin
            active_d = 1'b1;
            out_d    = 1'b1;
            pre_d    = '0;
          end else if (pre_cnt == PW'(PREAMBLE_LEN - 1)) begin
            state_d = FRAME;
            n_d     = '0;
            out_d   = cmd_bits[LAST_BIT];
          end else begin
            pre_d = pre_cnt + 1'b1;
          end
        end
      end
`endif
      FRAME: begin
        if (mdc_fall) begin
          active_d = 1'b1;
          n_d      = n_nxt;
          if (is_read && (n_nxt >= OE_CUT)) begin
            oe_d  = 1'b0;
            out_d = 1'b0;
          end else begin
            oe_d  = 1'b1;
            out_d = cmd_bits[LAST_BIT - n_nxt];
          end
        end else if (mdc_rise && active) begin
          if (is_read && (n >= RD_LO)) shreg_d = {shreg[13:0], MDIO_IN};
          if (n == LAST_BIT) begin
            state_d = DONE;
            if (is_read) begin
              rd_d  = {shreg, MDIO_IN};
              rdy_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (mdc_fall) begin
          oe_d     = 1'b0;
          out_d    = 1'b0;
          busy_d   = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MDIO_OUT = out_q;
  assign MDIO_OE  = oe_q;
  assign BUSY     = busy_q;
  assign DATA_RDY = rdy_q;
  assign RD_DATA  = rd_q;
endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller: acts as the MDIO target, captures frames bit by bit and checks them.
module tb_mdio_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MDIO_START = 1'b0;
  logic [31:0] T_DATA = '0;
  logic        MDIO_IN = 1'b0;
  logic        MDC, MDIO_OUT, MDIO_OE, DATA_RDY, BUSY;
  logic [15:0] RD_DATA;

  int checks = 0;
  int errors = 0;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif

  mdio_controller dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MDIO_START(MDIO_START),
    .T_DATA    (T_DATA),
    .MDIO_IN   (MDIO_IN),
    .MDC       (MDC),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .RD_DATA   (RD_DATA),
    .DATA_RDY  (DATA_RDY),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Results of the most recent run_frame call.
  logic [31:0] cap_bits, cap_oes;
  logic [15:0] rdy_val;
  int          rdy_pulses, rdy_idx, pre_ones;
  logic        end_busy, end_oe, busy_at_rdy, timed_out;

  // Called at a falling CLK edge; command is accepted on the next rising edge.
  task automatic issue(input logic [31:0] td);
    T_DATA     = td;
    MDIO_START = 1'b1;
    @(negedge CLK);
    MDIO_START = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] phy_rd, input int poke_at,
                           input logic [31:0] poke_td, input int abort_at);
    int   idx;
    logic started, prev, done;
    idx = 0; started = 1'b0; done = 1'b0; prev = MDC;
    cap_bits = '0; cap_oes = '0; rdy_val = '0; rdy_pulses = 0; rdy_idx = -99;
    pre_ones = 0; end_busy = 1'bx; end_oe = 1'bx; busy_at_rdy = 1'b0; timed_out = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge CLK);
      MDIO_START = 1'b0;
      if (DATA_RDY) begin
        rdy_pulses++;
        rdy_val = RD_DATA;
        rdy_idx = idx;
        busy_at_rdy = BUSY;
      end
      if (prev && !MDC) begin
        if (!started && MDIO_OE) begin
          started = 1'b1;
          idx = -PRE;
        end else if (started) begin
          idx++;
        end
        if (started) begin
          if (idx < 0) begin
            if (MDIO_OUT && MDIO_OE) pre_ones++;
          end else if (idx < 32) begin
            cap_bits[31-idx] = MDIO_OUT;
            cap_oes[31-idx]  = MDIO_OE;
            MDIO_IN = (idx >= 16) ? phy_rd[31-idx] : 1'b0;
          end else begin
            end_busy = BUSY;
            end_oe   = MDIO_OE;
            done     = 1'b1;
          end
          if (idx == poke_at) begin
            T_DATA     = poke_td;
            MDIO_START = 1'b1;
          end
          if (idx == abort_at) begin
            RESET = 1'b1;
            #1;
            done = 1'b1;
          end
        end
      end
      prev = MDC;
    end
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    #2 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (MDC !== 1'b0)        begin errors++; $display("FAIL rst_mdc got %b exp 0", MDC); end
    checks++; if (MDIO_OUT !== 1'b0)   begin errors++; $display("FAIL rst_out got %b exp 0", MDIO_OUT); end
    checks++; if (MDIO_OE !== 1'b0)    begin errors++; $display("FAIL rst_oe got %b exp 0", MDIO_OE); end
    checks++; if (RD_DATA !== 16'h0)   begin errors++; $display("FAIL rst_rd got %h exp 0000", RD_DATA); end
    checks++; if (DATA_RDY !== 1'b0)   begin errors++; $display("FAIL rst_rdy got %b exp 0", DATA_RDY); end
    checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (MDC !== 1'b1)        begin errors++; $display("FAIL mdc_first_high got %b exp 1", MDC); end
    @(negedge CLK);
    checks++; if (MDC !== 1'b0)        begin errors++; $display("FAIL mdc_then_low got %b exp 0", MDC); end
  endtask

  task automatic test_write();
    @(negedge CLK);
    issue(32'h5082_ABCD);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy_rise got %b exp 1", BUSY); end
    run_frame(16'h0000, -1, 32'h0, -1);
    checks++; if (timed_out !== 1'b0)         begin errors++; $display("FAIL wr_timeout got %b exp 0", timed_out); end
    checks++; if (cap_bits !== 32'h5082_ABCD) begin errors++; $display("FAIL wr_bits got %h exp 5082abcd", cap_bits); end
    checks++; if (cap_oes !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL wr_oe got %h exp ffffffff", cap_oes); end
    checks++; if (cap_bits[22:18] !== 5'h00)  begin errors++; $display("FAIL wr_addr got %h exp 00", cap_bits[22:18]); end
    checks++; if (cap_bits[15:0] !== 16'hABCD) begin errors++; $display("FAIL wr_data got %h exp abcd", cap_bits[15:0]); end
    checks++; if (pre_ones !== PRE)           begin errors++; $display("FAIL wr_preamble got %0d exp %0d", pre_ones, PRE); end
    checks++; if (rdy_pulses !== 0)           begin errors++; $display("FAIL wr_no_rdy got %0d exp 0", rdy_pulses); end
    checks++; if (end_busy !== 1'b0)          begin errors++; $display("FAIL wr_busy_end got %b exp 0", end_busy); end
    checks++; if (end_oe !== 1'b0)            begin errors++; $display("FAIL wr_oe_end got %b exp 0", end_oe); end
  endtask

  task automatic test_read();
    @(negedge CLK);
    issue(32'h6084_0000);
    run_frame(16'h1234, -1, 32'h0, -1);
    checks++; if (timed_out !== 1'b0)         begin errors++; $display("FAIL rd_timeout got %b exp 0", timed_out); end
    checks++; if (cap_bits !== 32'h6084_0000) begin errors++; $display("FAIL rd_bits got %h exp 60840000", cap_bits); end
    checks++; if (cap_oes !== 32'hFFFC_0000)  begin errors++; $display("FAIL rd_oe got %h exp fffc0000", cap_oes); end
    checks++; if (rdy_pulses !== 1)           begin errors++; $display("FAIL rd_rdy_count got %0d exp 1", rdy_pulses); end
    checks++; if (rdy_val !== 16'h1234)       begin errors++; $display("FAIL rd_value got %h exp 1234", rdy_val); end
    checks++; if (rdy_idx !== 31)             begin errors++; $display("FAIL rd_rdy_bit got %0d exp 31", rdy_idx); end
    checks++; if (busy_at_rdy !== 1'b1)       begin errors++; $display("FAIL rd_busy_at_rdy got %b exp 1", busy_at_rdy); end
    checks++; if (end_busy !== 1'b0)          begin errors++; $display("FAIL rd_busy_end got %b exp 0", end_busy); end
    checks++; if (RD_DATA !== 16'h1234)       begin errors++; $display("FAIL rd_hold got %h exp 1234", RD_DATA); end
  endtask

  task automatic test_invalid();
    logic [31:0] bad [2];
    logic        seen_busy, seen_oe;
    bad[0] = 32'h7000_0000;
    bad[1] = 32'h1000_0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      issue(bad[k]);
      seen_busy = BUSY;
      seen_oe   = MDIO_OE;
      repeat (8) begin
        @(negedge CLK);
        seen_busy |= BUSY;
        seen_oe   |= MDIO_OE;
      end
      checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL inv%0d_busy got %b exp 0", k, seen_busy); end
      checks++; if (seen_oe !== 1'b0)   begin errors++; $display("FAIL inv%0d_oe got %b exp 0", k, seen_oe); end
    end
  endtask

  task automatic test_start_ignored();
    logic seen_busy;
    @(negedge CLK);
    issue(32'h5082_ABCD);
    run_frame(16'h0000, 10, 32'h6084_0000, -1);
    checks++; if (cap_bits !== 32'h5082_ABCD) begin errors++; $display("FAIL ign_bits got %h exp 5082abcd", cap_bits); end
    checks++; if (cap_oes !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL ign_oe got %h exp ffffffff", cap_oes); end
    checks++; if (rdy_pulses !== 0)           begin errors++; $display("FAIL ign_rdy got %0d exp 0", rdy_pulses); end
    seen_busy = BUSY;
    repeat (6) begin
      @(negedge CLK);
      seen_busy |= BUSY;
    end
    checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL ign_no_retrigger got %b exp 0", seen_busy); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    issue(32'h5082_ABCD);
    run_frame(16'h0000, -1, 32'h0, -1);
    issue(32'h6084_0000);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", BUSY); end
    run_frame(16'hC3A5, -1, 32'h0, -1);
    checks++; if (cap_bits !== 32'h6084_0000) begin errors++; $display("FAIL b2b_bits got %h exp 60840000", cap_bits); end
    checks++; if (rdy_val !== 16'hC3A5)       begin errors++; $display("FAIL b2b_value got %h exp c3a5", rdy_val); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    issue(32'h6084_0000);
    run_frame(16'hFFFF, -1, 32'h0, 20);
    checks++; if (MDC !== 1'b0)        begin errors++; $display("FAIL mid_mdc got %b exp 0", MDC); end
    checks++; if (MDIO_OE !== 1'b0)    begin errors++; $display("FAIL mid_oe got %b exp 0", MDIO_OE); end
    checks++; if (MDIO_OUT !== 1'b0)   begin errors++; $display("FAIL mid_out got %b exp 0", MDIO_OUT); end
    checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL mid_busy got %b exp 0", BUSY); end
    checks++; if (RD_DATA !== 16'h0)   begin errors++; $display("FAIL mid_rd got %h exp 0000", RD_DATA); end
    checks++; if (DATA_RDY !== 1'b0)   begin errors++; $display("FAIL mid_rdy got %b exp 0", DATA_RDY); end
    checks++; if (rdy_pulses !== 0)    begin errors++; $display("FAIL mid_rdy_count got %0d exp 0", rdy_pulses); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    issue(32'h6084_0000);
    run_frame(16'hBEEF, -1, 32'h0, -1);
    checks++; if (timed_out !== 1'b0)   begin errors++; $display("FAIL post_timeout got %b exp 0", timed_out); end
    checks++; if (rdy_pulses !== 1)     begin errors++; $display("FAIL post_rdy_count got %0d exp 1", rdy_pulses); end
    checks++; if (RD_DATA !== 16'hBEEF) begin errors++; $display("FAIL post_value got %h exp beef", RD_DATA); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_controller.md
# mdio_controller

Station-management (MDIO master) sequencer that generates MDC and serializes one 32-bit Clause-22 management frame per command toward the `peripheral` MDIO target. It accepts a command word from the host side, drives MDIO_OUT/MDIO_OE bit by bit, and for reads deserializes MDIO_IN into RD_DATA. It sits between the host register interface and the MDIO pins and is the only block that sequences the serial bus.

## Interface
- DIV_HALF, 1: CLK cycles per MDC half-period; MDC period is 2×DIV_HALF CLK.
- PREAMBLE_LEN, 32: preamble bit count, used only with MDIO_PREAMBLE_EN.
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MDIO_START  in  1  command strobe, sampled only in IDLE.
- T_DATA  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data.
- MDIO_IN  in  1  serial data from target.
- MDC  out  1  management clock.
- MDIO_OUT  out  1  serial data to target.
- MDIO_OE  out  1  1 = controller drives the bus.
- RD_DATA  out  16  last read result.
- DATA_RDY  out  1  one-CLK pulse when RD_DATA updates.
- BUSY  out  1  high from command acceptance to end of frame.

## Operation
- States: IDLE, PREAMBLE (only with macro), FRAME, DONE.
- IDLE: MDIO_START=1 with ST=2'b01 and OP ∈ {2'b01 write, 2'b10 read} → latch T_DATA, BUSY=1, go to PREAMBLE/FRAME. Any other ST/OP → command dropped, no bus activity, no BUSY.
- MDIO_START while not in IDLE is ignored; T_DATA is not re-sampled.
- FRAME: 5-bit counter n = 0..31; bit n = latched T_DATA[31−n] on MDIO_OUT.
- Write: MDIO_OE=1 for n=0..31.
- Read: MDIO_OE=1 for n=0..13; MDIO_OE=0, MDIO_OUT=0 for n=14..31; MDIO_IN sampled for n=16..31 into shift register, MSB first.
- DONE: read → RD_DATA ← shift register, DATA_RDY=1 for one CLK; write → RD_DATA unchanged, no DATA_RDY. Then MDIO_OE=0, BUSY=0, return to IDLE.

## Timing
- Reset values: MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0, state IDLE, counter 0.
- MDC free-runs after reset, toggling every DIV_HALF CLK; with default, MDC period = 2 CLK.
- MDIO_OUT/MDIO_OE change only on the CLK edge where MDC goes 1→0; MDIO_IN sampled on the CLK edge where MDC goes 0→1.
- BUSY rises on the CLK edge accepting MDIO_START; bit 0 appears at the first following MDC falling transition (1 to 2×DIV_HALF CLK later).
- Each bit held one MDC period; frame = 32 MDC periods (+PREAMBLE_LEN with macro).
- DATA_RDY and RD_DATA update on the MDC rising edge that samples bit 31; BUSY falls and MDIO_OE=0 at the next MDC falling transition.
- Back-to-back: new MDIO_START accepted on the first CLK with BUSY=0.
- RESET mid-frame: all outputs return to reset values asynchronously; partial read data discarded; no DATA_RDY.

## Configuration
- MDIO_PREAMBLE_EN defined: PREAMBLE state drives MDIO_OE=1, MDIO_OUT=1 for PREAMBLE_LEN MDC periods before bit 0 of FRAME.
- Undefined: PREAMBLE state and its counter absent; FRAME begins directly after acceptance.

## Structure
- Package mdio_pkg: ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, T_DATA field bit positions, frame length 32, read OE cutoff bit 14, state enum.
- Sub-module mdc_clkgen: divider producing MDC plus one-CLK mdc_rise / mdc_fall enables consumed by the FSM.

## Test plan
- Write T_DATA=32'h5082_ABCD (ST 01, OP 01, PHY 01, REG 00, TA 10) → 32 MDC periods, MDIO_OE=1 throughout, serial bits equal T_DATA MSB-first; peripheral shows ADDR=5'h00, WR_DATA=16'hABCD, WR_STB pulse; no DATA_RDY.
- Read T_DATA=32'h6084_0000 (REG 01), peripheral RD_DATA=16'h1234 → MDIO_OE low from bit 14, RD_DATA=16'h1234, DATA_RDY exactly one CLK, BUSY low one MDC fall later.
- Invalid OP (T_DATA=32'h7000_0000) and invalid ST (32'h1000_0000) → BUSY stays 0, MDIO_OE stays 0.
- MDIO_START pulsed at bit 10 of a write → ignored, frame bits unchanged, next command accepted only after BUSY=0.
- RESET asserted at read bit 20 → immediate MDC=0, MDIO_OE=0, BUSY=0, RD_DATA=16'h0000, no DATA_RDY; subsequent read completes normally.
- With MDIO_PREAMBLE_EN: write shows 32 ones with MDIO_OE=1 before ST; total BUSY duration 64 MDC periods.
